// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary pointer conversion and pointer width
// calculation, used by both the read and the write side of the FIFO.
package fifo_pkg;

  localparam int GW = 32;

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int ptr_bits(input int depth);
    int n;
    n = 0;
    while ((1 << n) < depth) n++;
    return n;
  endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Two-entry in-order output buffer feeding the downstream valid/ready stream.
// Upstream credit logic guarantees a push never lands on a full buffer.
module fifo_rd_obuf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  valid,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_count;
  logic                  w_pop;
  logic                  w_push;

  assign w_pop  = (r_count != 2'd0) & ready;
  assign w_push = push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= din;
          else                 r_tail <= din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Count stays put; the new word joins behind whatever remains.
          if (r_count == 2'd1) begin
            r_head <= din;
          end else begin
            r_head <= r_tail;
            r_tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (r_count != 2'd0);
  assign dout  = r_head;
  assign count = r_count;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read side of an async FIFO presented as a valid/ready stream with 2-deep credit.
// Optional almost_empty output enabled by macro FIFO_RD_ALMOST_EMPTY_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ptr_width  = 4
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  parameter int AE_LEVEL   = 2
`endif
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [ptr_width:0]    wq2_wptr,
  input  logic [DATA_WIDTH-1:0] d_out,
  output logic                  rd_en,
  output logic [ptr_width-1:0]  rd_ptr,
  output logic [ptr_width:0]    rd_gptr,
  output logic                  empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic                  almost_empty
`endif
);

  localparam int PW1 = ptr_width + 1;

  if (((1 << ptr_width) != DEPTH) || (ptr_bits(DEPTH) != ptr_width)) begin : g_cfg_check
    $error("fifo_rd_stream: DEPTH must equal 2**ptr_width");
  end

  logic [ptr_width:0] r_rbin;
  logic [ptr_width:0] r_gptr;
  logic [ptr_width:0] w_rbin_nxt;
  logic               r_inflight;
  logic [1:0]         w_buf_cnt;
  logic               w_depart;
  logic [2:0]         w_occ;

  assign empty    = (r_gptr == wq2_wptr);
  assign w_depart = m_valid & m_ready;
  // Credit: buffered words plus the read in flight, net of a beat leaving now.
  assign w_occ    = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_depart};
  assign rd_en    = ~rd_rst & ~empty & (w_occ < 3'd2);

  assign w_rbin_nxt = r_rbin + {{ptr_width{1'b0}}, rd_en};
  assign rd_ptr     = r_rbin[ptr_width-1:0];
  assign rd_gptr    = r_gptr;

  // Read issue stage: pointer advance and in-flight tracking
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_rbin     <= '0;
      r_gptr     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_rbin     <= w_rbin_nxt;
      r_gptr     <= PW1'(bin2gray(GW'(w_rbin_nxt)));
      r_inflight <= rd_en;
    end
  end

  // Capture stage: memory data returned one cycle after the read
  fifo_rd_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk  (rd_clk),
    .rst  (rd_rst),
    .push (r_inflight),
    .din  (d_out),
    .valid(m_valid),
    .ready(m_ready),
    .dout (m_data),
    .count(w_buf_cnt)
  );

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic [ptr_width:0] w_wbin;
  logic [ptr_width:0] w_fill;
  logic               r_almost_empty;

  assign w_wbin = PW1'(gray2bin(GW'(wq2_wptr)));
  assign w_fill = w_wbin - r_rbin;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) r_almost_empty <= 1'b1;
    else        r_almost_empty <= (int'(w_fill) <= AE_LEVEL);
  end

  assign almost_empty = r_almost_empty;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: per-cycle vector table plus
// directed wrap, scoreboard and reset sequences against a small memory model.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] wptr = 5'd0;
  logic [7:0] d_out;
  logic       m_ready = 1'b0;
  wire        rd_en;
  wire  [3:0] rd_ptr;
  wire  [4:0] rd_gptr;
  wire        empty;
  wire        m_valid;
  wire  [7:0] m_data;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  wire        almost_empty;
`endif

  logic [7:0] mem [16];
  int errors = 0;
  int checks = 0;

  fifo_rd_stream dut (
    .rd_clk  (clk),
    .rd_rst  (rst),
    .wq2_wptr(wptr),
    .d_out   (d_out),
    .rd_en   (rd_en),
    .rd_ptr  (rd_ptr),
    .rd_gptr (rd_gptr),
    .empty   (empty),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: registered read, data one cycle after rd_en.
  always @(posedge clk) if (rd_en) d_out <= mem[rd_ptr];

  function automatic logic [4:0] gry(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      #1;
      if (empty && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  typedef struct {
    logic [4:0] wp;
    logic       rdy;
    logic       en;
    logic [3:0] ptr;
    logic       vld;
    logic [7:0] dat;
    logic       emp;
  } vec_t;

  vec_t tv [17];

  logic [4:0] wbin;
  logic [7:0] expq [$];
  logic [7:0] expd;
  logic [7:0] prev_data;
  logic [4:0] fill;
  bit         prev_stall;
  int         issued, delivered, wrote, occ_viol, stab_viol;

  initial begin
    // REQ-033: three words, m_ready high
    tv[0]  = '{5'd2,  1'b1, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0};
    tv[1]  = '{5'd2,  1'b1, 1'b1, 4'd1, 1'b0, 8'h00, 1'b0};
    tv[2]  = '{5'd2,  1'b1, 1'b1, 4'd2, 1'b1, 8'h11, 1'b0};
    tv[3]  = '{5'd2,  1'b1, 1'b0, 4'd3, 1'b1, 8'h22, 1'b1};
    tv[4]  = '{5'd2,  1'b1, 1'b0, 4'd3, 1'b1, 8'h33, 1'b1};
    tv[5]  = '{5'd2,  1'b1, 1'b0, 4'd3, 1'b0, 8'h00, 1'b1};
    // REQ-034: five words with m_ready low, then released
    tv[6]  = '{5'd12, 1'b0, 1'b1, 4'd3, 1'b0, 8'h00, 1'b0};
    tv[7]  = '{5'd12, 1'b0, 1'b1, 4'd4, 1'b0, 8'h00, 1'b0};
    tv[8]  = '{5'd12, 1'b0, 1'b0, 4'd5, 1'b1, 8'h40, 1'b0};
    tv[9]  = '{5'd12, 1'b0, 1'b0, 4'd5, 1'b1, 8'h40, 1'b0};
    tv[10] = '{5'd12, 1'b0, 1'b0, 4'd5, 1'b1, 8'h40, 1'b0};
    tv[11] = '{5'd12, 1'b1, 1'b1, 4'd5, 1'b1, 8'h40, 1'b0};
    tv[12] = '{5'd12, 1'b1, 1'b1, 4'd6, 1'b1, 8'h41, 1'b0};
    tv[13] = '{5'd12, 1'b1, 1'b1, 4'd7, 1'b1, 8'h42, 1'b0};
    tv[14] = '{5'd12, 1'b1, 1'b0, 4'd8, 1'b1, 8'h43, 1'b1};
    tv[15] = '{5'd12, 1'b1, 1'b0, 4'd8, 1'b1, 8'h44, 1'b1};
    tv[16] = '{5'd12, 1'b1, 1'b0, 4'd8, 1'b0, 8'h00, 1'b1};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    for (int i = 0; i < 5; i++) mem[3+i] = 8'h40 + 8'(i);

    // Reset state
    step(); step(); step();
    chk("rst_hold_rden", int'(rd_en), 0);
    rst = 1'b0;
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_rden", int'(rd_en), 0);
    chk("rst_mvalid", int'(m_valid), 0);
    chk("rst_gptr", int'(rd_gptr), 0);
    chk("rst_mdata", int'(m_data), 0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("rst_ae", int'(almost_empty), 1);
`endif

    // Table-driven cycles
    for (int i = 0; i < 17; i++) begin
      step();
      wptr    = tv[i].wp;
      m_ready = tv[i].rdy;
      #1;
      chk($sformatf("tv%0d_rden", i), int'(rd_en), int'(tv[i].en));
      chk($sformatf("tv%0d_rdptr", i), int'(rd_ptr), int'(tv[i].ptr));
      chk($sformatf("tv%0d_mvalid", i), int'(m_valid), int'(tv[i].vld));
      chk($sformatf("tv%0d_empty", i), int'(empty), int'(tv[i].emp));
      if (tv[i].vld) chk($sformatf("tv%0d_mdata", i), int'(m_data), int'(tv[i].dat));
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      if (i == 1) chk("ae_three_words", int'(almost_empty), 0);
`endif
    end

    // Pointer wrap: drive rbin up to 31, then one word across the wrap
    m_ready = 1'b1;
    step();
    wptr = gry(5'd24);
    wait_idle("wrap_drain1");
    step();
    wptr = gry(5'd31);
    wait_idle("wrap_drain2");
    chk("wrap_gptr31", int'(rd_gptr), int'(gry(5'd31)));
    mem[15] = 8'hA5;
    step();
    wptr = gry(5'd0);
    #1;
    chk("wrap_rden", int'(rd_en), 1);
    chk("wrap_rdptr", int'(rd_ptr), 15);
    step();
    #1;
    chk("wrap_gptr0", int'(rd_gptr), 0);
    chk("wrap_empty", int'(empty), 1);
    step();
    #1;
    chk("wrap_mvalid", int'(m_valid), 1);
    chk("wrap_mdata", int'(m_data), 8'hA5);

    // Scoreboard: 100 random writes, alternating m_ready
    wbin = 5'd0;
    issued = 0; delivered = 0; wrote = 0; occ_viol = 0; stab_viol = 0;
    prev_stall = 1'b0; prev_data = 8'h00;
    step();
    for (int cyc = 0; cyc < 3000 && delivered < 100; cyc++) begin
      step();
      m_ready = cyc[0];
      fill = wbin - g2b(rd_gptr);
      if (wrote < 100 && fill < 5'd16 && $urandom_range(0, 3) != 0) begin
        mem[wbin[3:0]] = 8'($urandom);
        expq.push_back(mem[wbin[3:0]]);
        wbin = wbin + 5'd1;
        wptr = gry(wbin);
        wrote++;
      end
      #1;
      if (prev_stall && (!m_valid || m_data !== prev_data)) stab_viol++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (rd_en) issued++;
      if (m_valid && m_ready) begin
        delivered++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got 0x%0h expected no beat", m_data);
        end else begin
          expd = expq.pop_front();
          chk("sb_data", int'(m_data), int'(expd));
        end
      end
      if (issued - delivered > 2) occ_viol++;
    end
    chk("sb_delivered", delivered, 100);
    chk("sb_leftover", expq.size(), 0);
    chk("sb_occupancy", occ_viol, 0);
    chk("sb_stable", stab_viol, 0);

    // Reset with a read in flight
    m_ready = 1'b1;
    wait_idle("rst_drain");
    step();
    m_ready = 1'b0;
    mem[wbin[3:0]] = 8'hEE;
    wbin = wbin + 5'd1;
    wptr = gry(wbin);
    #1;
    chk("rif_rden", int'(rd_en), 1);
    step();
    rst = 1'b1;
    #1;
    chk("rif_rden_forced", int'(rd_en), 0);
    step();
    #1;
    chk("rif_mvalid", int'(m_valid), 0);
    chk("rif_mdata", int'(m_data), 0);
    chk("rif_gptr", int'(rd_gptr), 0);
    chk("rif_rdptr", int'(rd_ptr), 0);
    step();
    rst = 1'b0;
    wbin = 5'd0;
    wptr = 5'd0;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rif_stale%0d", k), int'(m_valid), 0);
      step();
    end
    chk("rif_empty", int'(empty), 1);

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    m_ready = 1'b0;
    wptr = gry(5'd2);
    step();
    #1;
    chk("ae_two_words", int'(almost_empty), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of FIFO memory entries (power of two).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the word width.
REQ-003 The block SHALL have parameter ptr_width, default 4, meaning the memory address width, log2(DEPTH).
REQ-004 rd_clk  input  1  is the single clock; all logic SHALL be on its rising edge.
REQ-005 rd_rst  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-006 wq2_wptr  input  ptr_width+1  is the write pointer in Gray code, already synchronised into rd_clk.
REQ-007 d_out  input  DATA_WIDTH  is the memory read data, valid one cycle after an accepted read.
REQ-008 rd_en  output  1  is the memory read request.
REQ-009 rd_ptr  output  ptr_width  is the memory read address (binary).
REQ-010 rd_gptr  output  ptr_width+1  is the read pointer in Gray code, for synchronisation to the write side.
REQ-011 empty  output  1  is the FIFO empty flag, also driven to the memory.
REQ-012 m_valid, m_ready (input), m_data  1/1/DATA_WIDTH  form the downstream valid/ready stream.

Function
REQ-013 Internal state SHALL include a binary read pointer rbin of ptr_width+1 bits; rd_ptr SHALL equal rbin[ptr_width-1:0], and rd_gptr SHALL equal (rbin>>1)^rbin, registered.
REQ-014 empty SHALL be combinational: 1 iff rd_gptr == wq2_wptr.
REQ-015 Credit rule: occupancy (buffer entries + read in flight) SHALL never exceed 2.
REQ-016 rd_en SHALL be 1 iff !empty and occupancy counting a departing beat (m_valid && m_ready) is < 2.
REQ-017 When rd_en is 1, rbin SHALL increment by 1 at the clock edge and wrap modulo 2^(ptr_width+1).
REQ-018 One cycle after rd_en, d_out SHALL be written into a 2-entry output buffer in order.
REQ-019 m_valid SHALL be 1 iff the buffer is non-empty; m_data SHALL be the oldest entry.
REQ-020 m_data and m_valid SHALL hold stable while m_valid && !m_ready.
REQ-021 A beat leaves the buffer on m_valid && m_ready; a simultaneous write and leave SHALL keep the count unchanged.
REQ-022 Throughput SHALL be 1 beat per cycle while the FIFO is non-empty and m_ready is 1; first-word latency SHALL be 2 cycles from empty falling to m_valid.
REQ-023 Words SHALL be delivered exactly once, in write order, with none lost or duplicated under any m_ready pattern.

Reset
REQ-024 While rd_rst is 1 at an edge, the following SHALL be 0: rbin, rd_gptr, buffer count, in-flight flag, m_valid, and m_data.
REQ-025 During reset, rd_en SHALL be forced to 0.
REQ-026 A read in flight when reset is asserted SHALL be discarded.

Configuration
REQ-027 With macro FIFO_RD_ALMOST_EMPTY_EN defined, the block SHALL add parameter AE_LEVEL (default 2) and a registered output almost_empty.
REQ-028 almost_empty SHALL be 1 when (Gray-decoded wq2_wptr − rbin) mod 2^(ptr_width+1) <= AE_LEVEL, and SHALL reset to 1.
REQ-029 Without the macro, neither the port nor the logic SHALL exist.

Structure
REQ-030 The functions bin2gray and gray2bin and a width helper SHALL live in shared package fifo_pkg, also used by the write side.
REQ-031 The 2-entry output buffer SHALL be sub-module fifo_rd_obuf (parameter DATA_WIDTH; push, din, valid, ready, dout).

Verification
REQ-032 Reset, then wq2_wptr=0 -> empty=1, rd_en=0, m_valid=0, and rd_gptr=0.
REQ-033 wq2_wptr steps to gray(3) with m_ready=1 -> rd_en high for 3 cycles, rd_ptr 0,1,2; m_valid from cycle 2; data in order; then empty=1.
REQ-034 FIFO holds 5 words and m_ready=0 -> rd_en pulses exactly twice, m_valid=1 with m_data=word0 held; on release, words 0..4 come out back-to-back.
REQ-035 rbin starting at 31 (ptr_width=4) with one word available -> rd_ptr=15, rbin wraps to 0, and rd_gptr=0.
REQ-036 Alternating m_ready over 100 random writes -> scoreboard matches; occupancy never exceeds 2.
REQ-037 rd_rst asserted with a read in flight -> all outputs 0 next cycle; the stale d_out is not delivered.
REQ-038 With FIFO_RD_ALMOST_EMPTY_EN and AE_LEVEL=2 -> almost_empty=1 at 2 words, 0 at 3.
